// File: rtl/dn_counter_pkg.sv
// Shared types and constants for the loadable down counter.
package dn_counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/dn_counter.sv
// Loadable down counter with one-shot / auto-reload modes and a one-cycle
// terminal-count pulse.
module dn_counter
    import dn_counter_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             en,
    input  logic             mode,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count_out,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             mode_q, mode_d;
    logic             tc_q, tc_d;

    // Priority is stop > start > en; start is honoured from every state.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        tc_d     = 1'b0;
        if (stop) begin
            state_d = IDLE;
        end else if (start) begin
            state_d  = RUN;
            count_d  = load_val;
            reload_d = load_val;
            mode_d   = mode;
        end else if (state_q == RUN && en) begin
            if (count_q != '0) begin
                count_d = count_q - WIDTH'(1);
            end else begin
                tc_d = 1'b1;
                if (mode_q == MODE_RELOAD) begin
                    count_d = reload_q;
                end else begin
                    state_d = DONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            mode_q   <= MODE_ONESHOT;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
            tc_q     <= tc_d;
        end
    end

    assign count_out = count_q;
    assign tc        = tc_q;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_dn_counter.sv
// Directed bench for dn_counter: a behavioural model checked every cycle plus
// hand-computed expectations at each step of the test sequences.
module tb_dn_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       en = 1'b0;
    logic       mode = 1'b0;
    logic [1:0] load_val = 2'd0;
    logic [1:0] count_out;
    logic       tc, busy, done;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    dn_counter #(.WIDTH(2)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .en(en),
        .mode(mode), .load_val(load_val), .count_out(count_out), .tc(tc),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Model: "remaining" ticks, a latched reload value, and which phase we are in.
    int m_count = 0, m_reload = 0, m_mode = 0, m_phase = 0, m_tc = 0;
    localparam int P_IDLE = 0, P_RUN = 1, P_DONE = 2;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_count <= 0; m_reload <= 0; m_mode <= 0; m_phase <= P_IDLE; m_tc <= 0;
        end else begin
            m_tc <= 0;
            if (stop) begin
                m_phase <= P_IDLE;
            end else if (start) begin
                m_count <= int'(load_val); m_reload <= int'(load_val);
                m_mode <= int'(mode); m_phase <= P_RUN;
            end else if (m_phase == P_RUN && en) begin
                if (m_count > 0) m_count <= m_count - 1;
                else begin
                    m_tc <= 1;
                    if (m_mode == 1) m_count <= m_reload;
                    else m_phase <= P_DONE;
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_count", int'(count_out), m_count);
            check("model_tc",    int'(tc),        m_tc);
            check("model_busy",  int'(busy),      int'(m_phase == P_RUN));
            check("model_done",  int'(done),      int'(m_phase == P_DONE));
        end
    end

    // Apply inputs just after a falling edge, return at the next falling edge.
    task automatic drive(input logic s, input logic p, input logic e,
                         input logic m, input logic [1:0] lv);
        start = s; stop = p; en = e; mode = m; load_val = lv;
        @(negedge clk);
    endtask

    task automatic expect_out(input string name, input int c, input int t,
                              input int b, input int d);
        $display("step %s: count=%0d tc=%0b busy=%0b done=%0b",
                 name, count_out, tc, busy, done);
        check({name, "_count"}, int'(count_out), c);
        check({name, "_tc"},    int'(tc),        t);
        check({name, "_busy"},  int'(busy),      b);
        check({name, "_done"},  int'(done),      d);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        expect_out("in_reset", 0, 0, 0, 0);
        reset = 1'b1;
        chk_en = 1'b1;
        drive(0, 0, 1, 0, 2'd3); expect_out("idle0", 0, 0, 0, 0);
        drive(0, 0, 1, 0, 2'd3); expect_out("idle1", 0, 0, 0, 0);

        // One-shot, load 3
        drive(1, 0, 1, 0, 2'd3); expect_out("os_load", 3, 0, 1, 0);
        drive(0, 0, 1, 0, 2'd0); expect_out("os_2", 2, 0, 1, 0);
        drive(0, 0, 1, 0, 2'd0); expect_out("os_1", 1, 0, 1, 0);
        drive(0, 0, 1, 0, 2'd0); expect_out("os_0", 0, 0, 1, 0);
        drive(0, 0, 1, 0, 2'd0); expect_out("os_tc", 0, 1, 0, 1);
        drive(0, 0, 1, 0, 2'd0); expect_out("os_hold", 0, 0, 0, 1);

        // Auto-reload, load 2 (started from DONE)
        drive(1, 0, 1, 1, 2'd2); expect_out("ar_load", 2, 0, 1, 0);
        drive(0, 0, 1, 0, 2'd0); expect_out("ar_1", 1, 0, 1, 0);
        drive(0, 0, 1, 0, 2'd0); expect_out("ar_0", 0, 0, 1, 0);
        drive(0, 0, 1, 0, 2'd0); expect_out("ar_wrap", 2, 1, 1, 0);
        drive(0, 0, 1, 0, 2'd0); expect_out("ar_1b", 1, 0, 1, 0);
        drive(0, 0, 1, 0, 2'd0); expect_out("ar_0b", 0, 0, 1, 0);
        drive(0, 0, 1, 0, 2'd0); expect_out("ar_wrap2", 2, 1, 1, 0);

        // Gated enable, one-shot load 3 (restart during RUN)
        drive(1, 0, 1, 0, 2'd3); expect_out("g_load", 3, 0, 1, 0);
        drive(0, 0, 1, 0, 2'd0); expect_out("g_e1", 2, 0, 1, 0);
        drive(0, 0, 0, 0, 2'd0); expect_out("g_n1", 2, 0, 1, 0);
        drive(0, 0, 1, 0, 2'd0); expect_out("g_e2", 1, 0, 1, 0);
        drive(0, 0, 0, 0, 2'd0); expect_out("g_n2", 1, 0, 1, 0);
        drive(0, 0, 1, 0, 2'd0); expect_out("g_e3", 0, 0, 1, 0);
        drive(0, 0, 0, 0, 2'd0); expect_out("g_n3", 0, 0, 1, 0);
        drive(0, 0, 1, 0, 2'd0); expect_out("g_e4", 0, 1, 0, 1);

        // Abort and priority
        drive(1, 0, 0, 0, 2'd3); expect_out("ab_load", 3, 0, 1, 0);
        drive(0, 0, 1, 0, 2'd0); expect_out("ab_2", 2, 0, 1, 0);
        drive(0, 0, 1, 0, 2'd0); expect_out("ab_1", 1, 0, 1, 0);
        drive(0, 1, 1, 0, 2'd0); expect_out("ab_stop", 1, 0, 0, 0);
        drive(1, 1, 1, 0, 2'd2); expect_out("ab_both", 1, 0, 0, 0);
        drive(0, 0, 1, 0, 2'd2); expect_out("ab_idle", 1, 0, 0, 0);

        // Restart during RUN with load 2
        drive(1, 0, 0, 0, 2'd3); expect_out("rs_load", 3, 0, 1, 0);
        drive(0, 0, 1, 0, 2'd0); expect_out("rs_2", 2, 0, 1, 0);
        drive(0, 0, 1, 0, 2'd0); expect_out("rs_1", 1, 0, 1, 0);
        drive(1, 0, 1, 0, 2'd2); expect_out("rs_new", 2, 0, 1, 0);

        // load_val = 0 in both modes
        drive(1, 0, 1, 0, 2'd0); expect_out("z0_load", 0, 0, 1, 0);
        drive(0, 0, 1, 0, 2'd0); expect_out("z0_tc", 0, 1, 0, 1);
        drive(1, 0, 1, 1, 2'd0); expect_out("z1_load", 0, 0, 1, 0);
        drive(0, 0, 1, 0, 2'd0); expect_out("z1_tc1", 0, 1, 1, 0);
        drive(0, 0, 1, 0, 2'd0); expect_out("z1_tc2", 0, 1, 1, 0);
        drive(0, 0, 0, 0, 2'd0); expect_out("z1_hold", 0, 0, 1, 0);

        // Asynchronous reset between edges mid-run
        drive(1, 0, 1, 0, 2'd3); expect_out("ar_run", 3, 0, 1, 0);
        drive(0, 0, 1, 0, 2'd0); expect_out("ar_run2", 2, 0, 1, 0);
        #2 reset = 1'b0;
        #1 expect_out("async_rst", 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        drive(0, 0, 1, 0, 2'd3); expect_out("post_rst", 0, 0, 0, 0);
        drive(0, 0, 1, 0, 2'd3); expect_out("post_rst2", 0, 0, 0, 0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
